// File: rtl/state_bank.sv
// Multi-channel debounce, rising-edge detect and mode-driven state outputs.
// Define STATE_BANK_SYNC_EN to add a 2-flop input synchronizer per channel.
module state_bank #(
    parameter int CH        = 4,
    parameter int DB_CNT    = 16,
    parameter int DB_W      = 8,
    parameter int PULSE_LEN = 50,
    parameter int PL_W      = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [CH-1:0] transition,
    input  logic [1:0]    mode,
    input  logic          clear,
    output logic [CH-1:0] state,
    output logic [CH-1:0] edge_pulse
);

    typedef enum logic [1:0] {
        M_TOGGLE  = 2'b00,
        M_FOLLOW  = 2'b01,
        M_ONESHOT = 2'b10,
        M_HOLD    = 2'b11
    } mode_e;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CNT - 1);
    localparam logic [PL_W-1:0] PL_LOAD = PL_W'(PULSE_LEN - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [PL_W-1:0] PL_ONE  = PL_W'(1);

    mode_e mode_q;
    assign mode_q = mode_e'(mode);

    logic [CH-1:0] samp;

`ifdef STATE_BANK_SYNC_EN
    logic [CH-1:0] sync1;
    logic [CH-1:0] sync2;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= transition;
            sync2 <= sync1;
        end
    end

    assign samp = sync2;
`else
    assign samp = transition;
`endif

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [DB_W-1:0] cnt_q;
        logic [DB_W-1:0] cnt_n;
        logic            db_q;
        logic            db_n;
        logic            db_d;
        logic [PL_W-1:0] os_q;
        logic [PL_W-1:0] os_n;
        logic            st_q;
        logic            st_n;
        logic            rise;

        assign rise = db_q & ~db_d;

        // Accept a new level only after DB_CNT consecutive differing samples.
        always_comb begin
            cnt_n = cnt_q;
            db_n  = db_q;
            if (samp[i] == db_q) begin
                cnt_n = '0;
            end else if (cnt_q == DB_LAST) begin
                db_n  = samp[i];
                cnt_n = '0;
            end else begin
                cnt_n = cnt_q + DB_ONE;
            end
        end

        // One-shot counter is only live in ONESHOT; any other mode zeroes it.
        always_comb begin
            st_n = st_q;
            os_n = '0;
            if (clear) begin
                st_n = 1'b0;
            end else begin
                unique case (mode_q)
                    M_TOGGLE: begin
                        if (rise) st_n = ~st_q;
                    end
                    M_FOLLOW: begin
                        st_n = db_q;
                    end
                    M_ONESHOT: begin
                        if (rise) begin
                            st_n = 1'b1;
                            os_n = PL_LOAD;
                        end else if (os_q != '0) begin
                            os_n = os_q - PL_ONE;
                        end else begin
                            st_n = 1'b0;
                        end
                    end
                    M_HOLD: begin
                        st_n = st_q;
                    end
                endcase
            end
        end

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                cnt_q <= '0;
                db_q  <= 1'b0;
                db_d  <= 1'b0;
                os_q  <= '0;
                st_q  <= 1'b0;
                edge_pulse[i] <= 1'b0;
            end else begin
                cnt_q <= cnt_n;
                db_q  <= db_n;
                db_d  <= db_q;
                os_q  <= os_n;
                st_q  <= st_n;
                edge_pulse[i] <= rise;
            end
        end

        assign state[i] = st_q;
    end

endmodule

// File: tb/tb_state_bank.sv
// Randomized bench for state_bank: two instances against a behavioural model.
// Unit 0 uses DB_CNT=4/PULSE_LEN=1, unit 1 uses DB_CNT=1/PULSE_LEN=5.
module tb_state_bank;

    localparam int CH = 4;

    logic          CLK;
    logic          RST;
    logic [CH-1:0] tr;
    logic [1:0]    mode;
    logic          clear;
    logic [CH-1:0] st0, ep0, st1, ep1;

    int errors = 0;
    int checks = 0;

    int dbc_of[2] = '{4, 1};
    int pl_of[2]  = '{1, 5};

    state_bank #(
        .CH(CH), .DB_CNT(4), .DB_W(3), .PULSE_LEN(1), .PL_W(1)
    ) u0 (
        .CLK(CLK), .RST(RST), .transition(tr), .mode(mode),
        .clear(clear), .state(st0), .edge_pulse(ep0)
    );

    state_bank #(
        .CH(CH), .DB_CNT(1), .DB_W(1), .PULSE_LEN(5), .PL_W(3)
    ) u1 (
        .CLK(CLK), .RST(RST), .transition(tr), .mode(mode),
        .clear(clear), .state(st1), .edge_pulse(ep1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: level accepted once the last DB_CNT samples all
    // oppose it; one-shot tracked as edges elapsed since the trigger.
    logic [7:0] m_hist [2][CH];
    logic       m_dbq  [2][CH];
    logic       m_dbd  [2][CH];
    logic       m_st   [2][CH];
    logic       m_ep   [2][CH];
    logic       m_s1   [2][CH];
    logic       m_s2   [2][CH];
    int         m_age  [2][CH];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            for (int c = 0; c < CH; c++) begin
                m_hist[u][c] = '0;
                m_dbq[u][c]  = 1'b0;
                m_dbd[u][c]  = 1'b0;
                m_st[u][c]   = 1'b0;
                m_ep[u][c]   = 1'b0;
                m_s1[u][c]   = 1'b0;
                m_s2[u][c]   = 1'b0;
                m_age[u][c]  = pl_of[u];
            end
        end
    endtask

    task automatic model_step(int u);
        int   dbc;
        int   pl;
        logic s;
        logic rise;
        logic all_diff;
        dbc = dbc_of[u];
        pl  = pl_of[u];
        for (int c = 0; c < CH; c++) begin
`ifdef STATE_BANK_SYNC_EN
            s = m_s2[u][c];
            m_s2[u][c] = m_s1[u][c];
            m_s1[u][c] = tr[c];
`else
            s = tr[c];
`endif
            rise = m_dbq[u][c] & ~m_dbd[u][c];
            m_ep[u][c] = rise;
            if (clear) begin
                m_st[u][c]  = 1'b0;
                m_age[u][c] = pl;
            end else begin
                case (mode)
                    2'b00: begin
                        if (rise) m_st[u][c] = ~m_st[u][c];
                        m_age[u][c] = pl;
                    end
                    2'b01: begin
                        m_st[u][c]  = m_dbq[u][c];
                        m_age[u][c] = pl;
                    end
                    2'b10: begin
                        if (rise) begin
                            m_age[u][c] = 0;
                        end else if (m_age[u][c] < pl) begin
                            m_age[u][c]++;
                        end
                        m_st[u][c] = (m_age[u][c] < pl);
                    end
                    default: begin
                        m_age[u][c] = pl;
                    end
                endcase
            end
            m_dbd[u][c]  = m_dbq[u][c];
            m_hist[u][c] = {m_hist[u][c][6:0], s};
            all_diff = 1'b1;
            for (int k = 0; k < dbc; k++)
                if (m_hist[u][c][k] == m_dbq[u][c]) all_diff = 1'b0;
            if (all_diff) m_dbq[u][c] = s;
        end
    endtask

    task automatic compare(string tag);
        logic [CH-1:0] es0, ee0, es1, ee1;
        for (int c = 0; c < CH; c++) begin
            es0[c] = m_st[0][c];
            ee0[c] = m_ep[0][c];
            es1[c] = m_st[1][c];
            ee1[c] = m_ep[1][c];
        end
        check({tag, "_st0"}, 32'(st0), 32'(es0));
        check({tag, "_ep0"}, 32'(ep0), 32'(ee0));
        check({tag, "_st1"}, 32'(st1), 32'(es1));
        check({tag, "_ep1"}, 32'(ep1), 32'(ee1));
    endtask

    task automatic cyc(int n, string tag);
        repeat (n) begin
            @(posedge CLK);
            #1;
            if (RST) begin
                model_reset();
            end else begin
                model_step(0);
                model_step(1);
            end
            compare(tag);
        end
    endtask

    task automatic pulse_ch(int c, int hi, int lo, string tag);
        tr[c] = 1'b1;
        cyc(hi, tag);
        tr[c] = 1'b0;
        cyc(lo, tag);
    endtask

    initial begin
        RST   = 1'b1;
        tr    = '0;
        mode  = 2'b00;
        clear = 1'b0;
        model_reset();
        #2;
        compare("reset");
        cyc(2, "reset");
        RST = 1'b0;

        for (int r = 0; r < 3; r++) pulse_ch(0, 8, 8, "toggle");

        pulse_ch(1, 3, 6, "glitch");
        check("glitch_st0", 32'(st0[1]), 32'(0));
        pulse_ch(1, 8, 8, "debounce");

        mode = 2'b10;
        pulse_ch(2, 1, 10, "oneshot");
        pulse_ch(2, 1, 2, "retrig");
        pulse_ch(2, 1, 12, "retrig");

        mode = 2'b01;
        pulse_ch(3, 6, 10, "follow");
        mode = 2'b11;
        for (int r = 0; r < 3; r++) pulse_ch(3, 6, 6, "hold");

        mode  = 2'b00;
        clear = 1'b1;
        cyc(1, "pre_clr");
        clear = 1'b0;
        cyc(2, "pre_clr");
        tr[0] = 1'b1;
        cyc(1, "clr_prio");
        clear = 1'b1;
        cyc(1, "clr_prio");
        check("clr_prio_ep", 32'(ep1[0]), 32'(1));
        check("clr_prio_st", 32'(st1[0]), 32'(0));
        clear = 1'b0;
        tr[0] = 1'b0;
        cyc(8, "clr_after");

        mode = 2'b10;
        tr[2] = 1'b1;
        cyc(2, "os_pre_rst");
        check("os_live", 32'(st1[2]), 32'(1));
        #3;
        RST = 1'b1;
        #1;
        model_reset();
        compare("async_rst");
        cyc(2, "in_rst");
        #2;
        RST = 1'b0;
        cyc(8, "post_rst");

        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 4) == 0) tr[c] = ~tr[c];
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            clear = ($urandom_range(0, 49) == 0);
            cyc(1, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
